vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised video timing generator running entirely on clk. An integer
//   divider produces a one-clk pixel enable (p_tick). The horizontal and
//   vertical counters advance only on p_tick. Sync, blanking and start
//   pulses are registered on the same edge as the counters, so they always
//   line up with pixel_x/pixel_y.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   en           1 = run, 0 = freeze divider, counters and outputs
//   restart      synchronous soft restart back to the reset state
//   p_tick       pixel enable, one clk wide
//   hsync/vsync  sync outputs, at H_POL/V_POL level when active
//   video_on     inside the active display area
//   pixel_x/y    current horizontal/vertical count
//   line_start   one-clk pulse when pixel_x becomes 0
//   frame_start  one-clk pulse when (pixel_x, pixel_y) becomes (0, 0)
module vga_timing_gen #(
  parameter int CW      = 10,
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          restart,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DISP_C = CW'(H_DISP);
  localparam logic [CW-1:0] V_DISP_C = CW'(V_DISP);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt;
  logic          x_wrap;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hs_act_nxt;
  logic          vs_act_nxt;
  logic          vid_nxt;

  // Gated by reset_n so p_tick is low during reset even when CLK_DIV = 1,
  // where the divider compare is always true.
  assign p_tick = en & reset_n & (div_cnt == DIV_LAST);

  always_comb begin
    x_wrap     = (pixel_x == H_LAST);
    x_nxt      = x_wrap ? '0 : pixel_x + CW'(1);
    y_nxt      = pixel_y;
    if (x_wrap) begin
      y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + CW'(1);
    end
    hs_act_nxt = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
    vs_act_nxt = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
    vid_nxt    = (x_nxt < H_DISP_C) && (y_nxt < V_DISP_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (restart) begin
      div_cnt     <= '0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Start pulses are set only on a p_tick edge, so they drop one clk
      // later whatever the divider ratio or the state of en.
      line_start  <= p_tick && (x_nxt == '0);
      frame_start <= p_tick && (x_nxt == '0) && (y_nxt == '0);
      if (en) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      end
      if (p_tick) begin
        pixel_x  <= x_nxt;
        pixel_y  <= y_nxt;
        hsync    <= hs_act_nxt ? H_POL : ~H_POL;
        vsync    <= vs_act_nxt ? V_POL : ~V_POL;
        video_on <= vid_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instance A: default 640x480 timing, CLK_DIV = 4
  logic       reset_n_a, en_a, restart_a;
  logic       p_tick_a, hsync_a, vsync_a, video_on_a, ls_a, fs_a;
  logic [9:0] px_a, py_a;

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(reset_n_a), .en(en_a), .restart(restart_a),
    .p_tick(p_tick_a), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // Instance B: tiny 8x6 frame, CLK_DIV = 1, active-high syncs
  logic       reset_n_b, en_b, restart_b;
  logic       p_tick_b, hsync_b, vsync_b, video_on_b, ls_b, fs_b;
  logic [3:0] px_b, py_b;

  vga_timing_gen #(
    .CW(4), .CLK_DIV(1),
    .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n_b), .en(en_b), .restart(restart_b),
    .p_tick(p_tick_b), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b), .frame_start(fs_b)
  );

  initial begin
    int pt_n, hs_n, vs_n, vo_n, ls_n, fs_n, hs_bad, vs_bad, vo_bad;
    int hs_min, hs_max;
    int i;

    reset_n_a = 1'b0; en_a = 1'b1; restart_a = 1'b0;
    reset_n_b = 1'b0; en_b = 1'b1; restart_b = 1'b0;
    tick(3);

    // ---------------- instance A: reset state
    check("a_rst_x",   px_a, 799);
    check("a_rst_y",   py_a, 524);
    check("a_rst_hs",  hsync_a, 1);
    check("a_rst_vs",  vsync_a, 1);
    check("a_rst_vo",  video_on_a, 0);
    check("a_rst_pt",  p_tick_a, 0);
    check("a_rst_fs",  fs_a, 0);

    // first p_tick lands on the 4th clk after release
    reset_n_a = 1'b1;
    tick(3);
    check("a_pt_first", p_tick_a, 1);
    check("a_pre_x",    px_a, 799);
    tick(1);
    check("a_first_x",  px_a, 0);
    check("a_first_y",  py_a, 0);
    check("a_first_fs", fs_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_vo", video_on_a, 1);
    check("a_first_hs", hsync_a, 1);
    check("a_first_vs", vsync_a, 1);
    check("a_first_pt", p_tick_a, 0);
    tick(1);
    check("a_fs_clear", fs_a, 0);
    check("a_ls_clear", ls_a, 0);

    // one full line: 800 pixels x 4 clks
    pt_n = 0; hs_n = 0; vo_n = 0; ls_n = 0; fs_n = 0; hs_bad = 0; vo_bad = 0;
    hs_min = 1023; hs_max = 0;
    for (int k = 0; k < 3200; k++) begin
      tick(1);
      if (p_tick_a) pt_n++;
      if (ls_a) ls_n++;
      if (fs_a) fs_n++;
      if (!hsync_a) begin
        hs_n++;
        if (int'(px_a) < hs_min) hs_min = int'(px_a);
        if (int'(px_a) > hs_max) hs_max = int'(px_a);
      end
      if (((px_a >= 656) && (px_a <= 751)) == hsync_a) hs_bad++;
      if (video_on_a) vo_n++;
      if (video_on_a != ((px_a < 640) && (py_a < 480))) vo_bad++;
    end
    check("a_line_pticks", pt_n, 800);
    check("a_line_hs_clks", hs_n, 384);
    check("a_line_hs_min", hs_min, 656);
    check("a_line_hs_max", hs_max, 751);
    check("a_line_hs_bad", hs_bad, 0);
    check("a_line_vo_clks", vo_n, 2560);
    check("a_line_vo_bad", vo_bad, 0);
    check("a_line_ls_n", ls_n, 1);
    check("a_line_fs_n", fs_n, 0);
    check("a_line_end_x", px_a, 0);
    check("a_line_end_y", py_a, 1);

    // freeze at pixel_x = 100
    for (i = 0; i < 1000 && px_a != 10'd100; i++) tick(1);
    check("a_reach_x100", px_a, 100);
    en_a = 1'b0;
    pt_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (p_tick_a) pt_n++;
    end
    check("a_hold_pt", pt_n, 0);
    check("a_hold_x",  px_a, 100);
    check("a_hold_y",  py_a, 1);
    check("a_hold_hs", hsync_a, 1);
    check("a_hold_vo", video_on_a, 1);
    en_a = 1'b1;
    tick(3);
    check("a_resume_x",  px_a, 100);
    check("a_resume_pt", p_tick_a, 1);
    tick(1);
    check("a_resume_x1", px_a, 101);

    // restart together with en = 0 at pixel_x = 300
    for (i = 0; i < 2000 && px_a != 10'd300; i++) tick(1);
    check("a_reach_x300", px_a, 300);
    en_a = 1'b0;
    restart_a = 1'b1;
    tick(1);
    restart_a = 1'b0;
    check("a_rs_x",  px_a, 799);
    check("a_rs_y",  py_a, 524);
    check("a_rs_vo", video_on_a, 0);
    check("a_rs_hs", hsync_a, 1);
    check("a_rs_vs", vsync_a, 1);
    en_a = 1'b1;
    tick(3);
    check("a_rs_pt", p_tick_a, 1);
    tick(1);
    check("a_rs_fs", fs_a, 1);
    check("a_rs_x0", px_a, 0);
    check("a_rs_y0", py_a, 0);

    // ---------------- instance B: reset state (en = 1 throughout)
    check("b_rst_x",  px_b, 7);
    check("b_rst_y",  py_b, 5);
    check("b_rst_hs", hsync_b, 0);
    check("b_rst_vs", vsync_b, 0);
    check("b_rst_pt", p_tick_b, 0);
    reset_n_b = 1'b1;
    tick(1);
    check("b_first_x",  px_b, 0);
    check("b_first_y",  py_b, 0);
    check("b_first_fs", fs_b, 1);
    check("b_first_ls", ls_b, 1);
    check("b_first_vo", video_on_b, 1);
    check("b_first_hs", hsync_b, 0);

    // one full frame: 8 x 6 clks
    pt_n = 0; hs_n = 0; vs_n = 0; vo_n = 0; ls_n = 0; fs_n = 0;
    hs_bad = 0; vs_bad = 0;
    for (int k = 0; k < 48; k++) begin
      tick(1);
      if (p_tick_b) pt_n++;
      if (hsync_b) hs_n++;
      if (vsync_b) vs_n++;
      if (video_on_b) vo_n++;
      if (ls_b) ls_n++;
      if (fs_b) fs_n++;
      if (((px_b >= 5) && (px_b <= 6)) != hsync_b) hs_bad++;
      if ((py_b == 4) != vsync_b) vs_bad++;
    end
    check("b_frame_pt", pt_n, 48);
    check("b_frame_hs_n", hs_n, 12);
    check("b_frame_hs_bad", hs_bad, 0);
    check("b_frame_vs_n", vs_n, 8);
    check("b_frame_vs_bad", vs_bad, 0);
    check("b_frame_vo_n", vo_n, 12);
    check("b_frame_ls_n", ls_n, 6);
    check("b_frame_fs_n", fs_n, 1);
    check("b_frame_end_x", px_b, 0);
    check("b_frame_end_y", py_b, 0);

    // asynchronous reset mid-frame, between clock edges
    tick(20);
    check("b_mid_x", px_b, 4);
    check("b_mid_y", py_b, 2);
    #2;
    reset_n_b = 1'b0;
    #1;
    check("b_async_x",  px_b, 7);
    check("b_async_y",  py_b, 5);
    check("b_async_hs", hsync_b, 0);
    check("b_async_vs", vsync_b, 0);
    check("b_async_vo", video_on_b, 0);
    check("b_async_pt", p_tick_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
